// File: rtl/regfile_pkg.sv
// Shared types and width defaults for the register-file writeback arbiter.
package regfile_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_WIDTH      = 32;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_WIDTH-1:0]      data;
    } wb_req_t;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/wb_queue.sv
// Small writeback request FIFO; exposes the head plus per-slot valid/addr
// so the top level can answer pending-write queries.
module wb_queue
    import regfile_pkg::*;
#(
    parameter int  QDEPTH     = 2,
    parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter type req_t      = wb_req_t
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push,
    input  req_t                                push_req,
    input  logic                                pop,
    output req_t                                head,
    output logic                                full,
    output logic                                empty,
    output logic [QDEPTH-1:0]                   entry_valid,
    output logic [QDEPTH-1:0][ADDR_WIDTH-1:0]   entry_addr
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    req_t              mem_r [QDEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [QDEPTH-1:0] vld_r;
    logic              push_s;
    logic              pop_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        if (ptr == PW'(QDEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    assign full   = (count_r == CW'(QDEPTH));
    assign empty  = (count_r == CW'(0));
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    // Pointers, occupancy and slot storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            vld_r    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_req;
                vld_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                vld_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r        <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head and per-slot views for the query compare.
    always_comb begin
        head        = mem_r[rd_ptr_r];
        entry_valid = vld_r;
        for (int i = 0; i < QDEPTH; i++) begin
            entry_addr[i] = mem_r[i].addr;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// and load-return writeback queues, with a pending-write hazard query.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int QDEPTH      = 2,
    parameter int ZERO_REG_RO = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [WIDTH-1:0]      alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0]      mem_data,
    output logic                  reg_write_en,
    output logic [ADDR_WIDTH-1:0] destination_reg,
    output logic [WIDTH-1:0]      write_data,
    input  logic [ADDR_WIDTH-1:0] query_addr,
    output logic                  query_hit,
    output logic                  wb_pending
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      data;
    } req_t;

    req_t                              alu_req_s, mem_req_s;
    req_t                              alu_head_s, mem_head_s, gnt_req_s;
    logic                              alu_full_s, alu_empty_s, mem_full_s, mem_empty_s;
    logic [QDEPTH-1:0]                 alu_vld_s, mem_vld_s;
    logic [QDEPTH-1:0][ADDR_WIDTH-1:0] alu_slot_s, mem_slot_s;
    logic                              grant_vld_s, alu_pop_s, mem_pop_s, drop_s, hit_any_s;
    grant_e                            grant_s, last_grant_r;
    logic                              we_r;
    logic [ADDR_WIDTH-1:0]             dest_r;
    logic [WIDTH-1:0]                  data_r;

    assign alu_req_s = '{addr: alu_addr, data: alu_data};
    assign mem_req_s = '{addr: mem_addr, data: mem_data};

    wb_queue #(.QDEPTH(QDEPTH), .ADDR_WIDTH(ADDR_WIDTH), .req_t(req_t)) u_alu_q (
        .clk(clk), .rst_n(rst_n),
        .push(alu_valid), .push_req(alu_req_s), .pop(alu_pop_s),
        .head(alu_head_s), .full(alu_full_s), .empty(alu_empty_s),
        .entry_valid(alu_vld_s), .entry_addr(alu_slot_s)
    );

    wb_queue #(.QDEPTH(QDEPTH), .ADDR_WIDTH(ADDR_WIDTH), .req_t(req_t)) u_mem_q (
        .clk(clk), .rst_n(rst_n),
        .push(mem_valid), .push_req(mem_req_s), .pop(mem_pop_s),
        .head(mem_head_s), .full(mem_full_s), .empty(mem_empty_s),
        .entry_valid(mem_vld_s), .entry_addr(mem_slot_s)
    );

    assign alu_ready = !alu_full_s;
    assign mem_ready = !mem_full_s;

    // Round-robin choice between the two queue heads.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = GNT_ALU;
        if (!alu_empty_s && !mem_empty_s) begin
            grant_vld_s = 1'b1;
            grant_s     = (last_grant_r == GNT_MEM) ? GNT_ALU : GNT_MEM;
        end else if (!alu_empty_s) begin
            grant_vld_s = 1'b1;
            grant_s     = GNT_ALU;
        end else if (!mem_empty_s) begin
            grant_vld_s = 1'b1;
            grant_s     = GNT_MEM;
        end else begin
            grant_vld_s = 1'b0;
        end
    end

    assign alu_pop_s = grant_vld_s && (grant_s == GNT_ALU);
    assign mem_pop_s = grant_vld_s && (grant_s == GNT_MEM);
    assign gnt_req_s = (grant_s == GNT_ALU) ? alu_head_s : mem_head_s;
    assign drop_s    = (ZERO_REG_RO != 0) && (gnt_req_s.addr == '0);

    // Write stage; a dropped address-0 grant still consumes its turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= GNT_MEM;
            we_r         <= 1'b0;
            dest_r       <= '0;
            data_r       <= '0;
        end else if (grant_vld_s) begin
            last_grant_r <= grant_s;
            we_r         <= !drop_s;
            if (!drop_s) begin
                dest_r <= gnt_req_s.addr;
                data_r <= gnt_req_s.data;
            end
        end else begin
            we_r <= 1'b0;
        end
    end

    assign reg_write_en    = we_r;
    assign destination_reg = dest_r;
    assign write_data      = data_r;

    // Pending-write lookup across both queues and the write stage.
    always_comb begin
        hit_any_s = we_r && (dest_r == query_addr);
        for (int i = 0; i < QDEPTH; i++) begin
            if (alu_vld_s[i] && (alu_slot_s[i] == query_addr)) begin
                hit_any_s = 1'b1;
            end else if (mem_vld_s[i] && (mem_slot_s[i] == query_addr)) begin
                hit_any_s = 1'b1;
            end else begin
                hit_any_s = hit_any_s;
            end
        end
    end

    assign query_hit  = hit_any_s && !((ZERO_REG_RO != 0) && (query_addr == '0));
    assign wb_pending = !alu_empty_s || !mem_empty_s || we_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed vector table, reset and saturation sequences,
// and random traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int AW = 5;
    localparam int W  = 32;
    localparam int QD = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, mem_valid;
    logic          alu_ready, mem_ready;
    logic [AW-1:0] alu_addr, mem_addr, query_addr, destination_reg;
    logic [W-1:0]  alu_data, mem_data, write_data;
    logic          reg_write_en, query_hit, wb_pending;

    int n_vec = 0;
    int n_err = 0;

    regfile_wb_arbiter #(.ADDR_WIDTH(AW), .WIDTH(W), .QDEPTH(QD), .ZERO_REG_RO(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .reg_write_en(reg_write_en), .destination_reg(destination_reg), .write_data(write_data),
        .query_addr(query_addr), .query_hit(query_hit), .wb_pending(wb_pending)
    );

    always #5 clk = ~clk;

    // Reference model: two bounded FIFOs and an expected write stage.
    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } ent_t;

    ent_t          aq[$];
    ent_t          mq[$];
    bit            m_last_alu;
    bit            m_we;
    logic [AW-1:0] m_dest;
    logic [W-1:0]  m_data;
    bit            a_acc, m_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        aq.delete();
        mq.delete();
        m_last_alu = 1'b0;
        m_we       = 1'b0;
        m_dest     = '0;
        m_data     = '0;
    endtask

    function automatic bit m_hit(input logic [AW-1:0] qa);
        if (qa == 0) return 1'b0;
        foreach (aq[i]) if (aq[i].addr == qa) return 1'b1;
        foreach (mq[i]) if (mq[i].addr == qa) return 1'b1;
        return m_we && (m_dest == qa);
    endfunction

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        int   g;
        ent_t e;
        #1;
        chk("alu_ready", alu_ready, aq.size() < QD);
        chk("mem_ready", mem_ready, mq.size() < QD);
        chk("reg_write_en", reg_write_en, m_we);
        if (m_we) begin
            chk("destination_reg", destination_reg, m_dest);
            chk("write_data", write_data, m_data);
        end
        chk("wb_pending", wb_pending, (aq.size() > 0) || (mq.size() > 0) || m_we);
        chk("query_hit", query_hit, m_hit(query_addr));
        a_acc = alu_valid && (aq.size() < QD);
        m_acc = mem_valid && (mq.size() < QD);
        g = 0;
        if (aq.size() > 0 && mq.size() > 0) g = m_last_alu ? 2 : 1;
        else if (aq.size() > 0) g = 1;
        else if (mq.size() > 0) g = 2;
        m_we = 1'b0;
        if (g != 0) begin
            e = (g == 1) ? aq.pop_front() : mq.pop_front();
            m_last_alu = (g == 1);
            if (e.addr != 0) begin
                m_we   = 1'b1;
                m_dest = e.addr;
                m_data = e.data;
            end
        end
        if (a_acc) aq.push_back('{alu_addr, alu_data});
        if (m_acc) mq.push_back('{mem_addr, mem_data});
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit            av;
        logic [AW-1:0] aa;
        logic [W-1:0]  ad;
        bit            mv;
        logic [AW-1:0] ma;
        logic [W-1:0]  md;
        logic [AW-1:0] qa;
        bit            e_we;
        logic [AW-1:0] e_dest;
        logic [W-1:0]  e_data;
        bit            e_hit;
    } vec_t;

    function automatic vec_t mk(bit av, logic [AW-1:0] aa, logic [W-1:0] ad,
                                bit mv, logic [AW-1:0] ma, logic [W-1:0] md,
                                logic [AW-1:0] qa, bit e_we, logic [AW-1:0] e_dest,
                                logic [W-1:0] e_data, bit e_hit);
        vec_t v;
        v = '{av, aa, ad, mv, ma, md, qa, e_we, e_dest, e_data, e_hit};
        return v;
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return '0;
        return AW'($urandom_range(1, 31));
    endfunction

    vec_t tbl[14];
    int   an, mn;

    initial begin
        tbl[0]  = mk(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  5'd3, 1'b0, 5'd0, 32'h0,        1'b0);
        tbl[1]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd3, 1'b0, 5'd0, 32'h0,        1'b1);
        tbl[2]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd3, 1'b1, 5'd3, 32'hDEADBEEF, 1'b1);
        tbl[3]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd3, 1'b0, 5'd0, 32'h0,        1'b0);
        tbl[4]  = mk(1'b1, 5'd0, 32'h1,        1'b0, 5'd0, 32'h0,  5'd0, 1'b0, 5'd0, 32'h0,        1'b0);
        tbl[5]  = mk(1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 32'h0,  5'd0, 1'b0, 5'd0, 32'h0,        1'b0);
        tbl[6]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd4, 1'b0, 5'd0, 32'h0,        1'b1);
        tbl[7]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd4, 1'b1, 5'd4, 32'h44,       1'b1);
        tbl[8]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd4, 1'b0, 5'd0, 32'h0,        1'b0);
        tbl[9]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77, 5'd8, 1'b0, 5'd0, 32'h0,        1'b0);
        tbl[10] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd7, 1'b0, 5'd0, 32'h0,        1'b1);
        tbl[11] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd7, 1'b1, 5'd7, 32'h77,       1'b1);
        tbl[12] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd7, 1'b0, 5'd0, 32'h0,        1'b0);
        tbl[13] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd8, 1'b0, 5'd0, 32'h0,        1'b0);

        rst_n = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        query_addr = '0;
        model_reset();
        #3;
        chk("rst_we", reg_write_en, 1'b0);
        chk("rst_dest", destination_reg, 5'd0);
        chk("rst_data", write_data, 32'h0);
        chk("rst_pending", wb_pending, 1'b0);
        chk("rst_hit", query_hit, 1'b0);
        chk("rst_alu_ready", alu_ready, 1'b1);
        chk("rst_mem_ready", mem_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: single write latency, address 0 drop, query window.
        for (int i = 0; i < 14; i++) begin
            alu_valid = tbl[i].av; alu_addr = tbl[i].aa; alu_data = tbl[i].ad;
            mem_valid = tbl[i].mv; mem_addr = tbl[i].ma; mem_data = tbl[i].md;
            query_addr = tbl[i].qa;
            #1;
            chk($sformatf("tbl%0d_we", i), reg_write_en, tbl[i].e_we);
            if (tbl[i].e_we) begin
                chk($sformatf("tbl%0d_dest", i), destination_reg, tbl[i].e_dest);
                chk($sformatf("tbl%0d_data", i), write_data, tbl[i].e_data);
            end
            chk($sformatf("tbl%0d_hit", i), query_hit, tbl[i].e_hit);
            step();
        end

        // Reset in the middle of traffic with entries still queued.
        for (int i = 0; i < 2; i++) begin
            alu_valid = 1'b1; alu_addr = AW'(10 + i); alu_data = 32'hA0 + i;
            mem_valid = 1'b1; mem_addr = AW'(20 + i); mem_data = 32'hB0 + i;
            query_addr = 5'd21;
            step();
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", reg_write_en, 1'b0);
        chk("midrst_pending", wb_pending, 1'b0);
        chk("midrst_alu_ready", alu_ready, 1'b1);
        chk("midrst_mem_ready", mem_ready, 1'b1);
        chk("midrst_hit", query_hit, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) step();

        // Both requesters saturating for six cycles, then drain.
        an = 1; mn = 17;
        for (int c = 0; c < 12; c++) begin
            alu_valid = (c < 6); alu_addr = AW'(an); alu_data = 32'hA000_0000 | an;
            mem_valid = (c < 6); mem_addr = AW'(mn); mem_data = 32'hB000_0000 | mn;
            query_addr = AW'(an);
            step();
            if (a_acc) an++;
            if (m_acc) mn++;
            if (c == 2) chk("sat_alternating_we", reg_write_en, 1'b1);
        end

        // Random traffic; a refused request is held until accepted.
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!(alu_valid && !a_acc)) begin
                alu_valid = ($urandom_range(0, 99) < 65);
                alu_addr  = rnd_addr();
                alu_data  = $urandom();
            end
            if (!(mem_valid && !m_acc)) begin
                mem_valid = ($urandom_range(0, 99) < 65);
                mem_addr  = rnd_addr();
                mem_data  = $urandom();
            end
            case ($urandom_range(0, 2))
                0:       query_addr = alu_addr;
                1:       query_addr = mem_addr;
                default: query_addr = rnd_addr();
            endcase
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
